steer_en_fsm: RTL and testbench

- Downstream consumer of the A2D interface's `lft_ld`/`rght_ld` load-cell readings (12-bit, unsigned).
- Decides whether a rider is present and balanced.
- Asserts `en_steer` after the rider has stood balanced for a fixed settle time (~1.34 s at 50 MHz).
- Pulses `rider_off` when the rider steps off. The balance controller and motor drive enable use these outputs.

---
 rtl/segway_pkg.sv | 20 ++
 rtl/steer_tmr.sv | 39 +++
 rtl/steer_en_fsm.sv | 120 ++++++++++++
 tb/tb_steer_en_fsm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Shared types and constants for the Segway rider-detect / steer-enable logic.
package segway_pkg;

  localparam int unsigned LD_W  = 12;
  localparam int unsigned SUM_W = 13;
  localparam int unsigned TMR_W = 26;

  localparam logic [LD_W-1:0] MIN_RIDER_WT_DFLT = 12'h200;
  localparam logic [LD_W-1:0] WT_HYST_DFLT      = 12'h040;

  localparam logic [TMR_W-1:0] TMR_FULL_FAST = 26'h000_7FFF;
  localparam logic [TMR_W-1:0] TMR_FULL_SLOW = 26'h3FF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_state_t;

endpackage

// File: rtl/steer_tmr.sv
// Settle timer: counts balanced cycles in WAIT, saturating at the full value.
module steer_tmr
  import segway_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tmr_full
);

  localparam logic [TMR_W-1:0] TMR_FULL = FAST_SIM ? TMR_FULL_FAST : TMR_FULL_SLOW;

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  assign tmr_full = (cnt_q == TMR_FULL);

  // Clear wins over increment; holding at full keeps the count from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !tmr_full) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/steer_en_fsm.sv
// Rider presence / balance FSM: enables steering after a settle time, flags step-off.
module steer_en_fsm
  import segway_pkg::*;
#(
  parameter logic [LD_W-1:0] MIN_RIDER_WT = MIN_RIDER_WT_DFLT,
  parameter logic [LD_W-1:0] WT_HYST      = WT_HYST_DFLT,
  parameter bit              FAST_SIM     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            en_steer,
  output logic            rider_off
);

  localparam logic [LD_W-1:0] LOSS_WT = MIN_RIDER_WT - WT_HYST;

  steer_state_t state_q;
  steer_state_t state_d;

  logic [SUM_W-1:0] sum;
  logic [LD_W-1:0]  diff;
  logic             sum_gt_min;
  logic             sum_lt_min;
  logic             diff_gt_1_4;
  logic             diff_gt_15_16;

  logic tmr_clr;
  logic tmr_inc;
  logic tmr_full;
  logic lost;
  logic en_steer_d;
  logic rider_off_d;

  // Load-cell arithmetic, all zero-extended so nothing truncates.
  always_comb begin
    sum           = SUM_W'(lft_ld) + SUM_W'(rght_ld);
    diff          = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    sum_gt_min    = sum > SUM_W'(MIN_RIDER_WT);
    sum_lt_min    = sum < SUM_W'(LOSS_WT);
    diff_gt_1_4   = 14'({diff, 2'b00}) > 14'(sum);
    diff_gt_15_16 = 17'({diff, 4'b0000}) > (17'(sum) * 17'd15);
  end

  steer_tmr #(
    .FAST_SIM(FAST_SIM)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .tmr_full(tmr_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Weight loss beats imbalance, imbalance beats timer expiry.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    lost    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sum_gt_min) begin
          state_d = WAIT;
          tmr_clr = 1'b1;
        end
      end
      WAIT: begin
        if (sum_lt_min) begin
          state_d = IDLE;
          lost    = 1'b1;
        end else if (diff_gt_1_4) begin
          tmr_clr = 1'b1;
        end else if (tmr_full) begin
          state_d = STEER;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      STEER: begin
        if (sum_lt_min) begin
          state_d = IDLE;
          lost    = 1'b1;
        end else if (diff_gt_15_16) begin
          state_d = WAIT;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    en_steer_d  = (state_d == STEER);
    rider_off_d = lost;
  end

  // Outputs registered so en_steer tracks the state on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_steer  <= 1'b0;
      rider_off <= 1'b0;
    end else begin
      en_steer  <= en_steer_d;
      rider_off <= rider_off_d;
    end
  end

endmodule

// File: tb/tb_steer_en_fsm.sv
// Directed bench for steer_en_fsm; instance b only exercises reset in STEER.
module tb_steer_en_fsm;
  import segway_pkg::*;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic [11:0] lft;
  logic [11:0] rght;
  logic        en_a;
  logic        ro_a;
  logic        en_b;
  logic        ro_b;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  steer_en_fsm #(.FAST_SIM(1'b1)) dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .lft_ld   (lft),
    .rght_ld  (rght),
    .en_steer (en_a),
    .rider_off(ro_a)
  );

  steer_en_fsm #(.FAST_SIM(1'b1)) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .lft_ld   (lft),
    .rght_ld  (rght),
    .en_steer (en_b),
    .rider_off(ro_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
    lft  = l;
    rght = r;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_ld(12'h300, 12'h300);
    step(2);
    check("rst_en", 32'(en_a), 32'd0);
    check("rst_ro", 32'(ro_a), 32'd0);
    check("rst_state", 32'(dut_a.state_q), 32'(IDLE));
    check("rst_cnt", 32'(dut_a.u_tmr.cnt_q), 32'd0);

    // Release with a balanced rider: IDLE -> WAIT on the first edge.
    rst_a = 1'b0;
    rst_b = 1'b0;
    set_ld(12'h180, 12'h180);
    step(1);
    check("wait_entry_state", 32'(dut_a.state_q), 32'(WAIT));
    check("wait_entry_cnt", 32'(dut_a.u_tmr.cnt_q), 32'd0);
    step(100);
    check("cnt_100", 32'(dut_a.u_tmr.cnt_q), 32'd100);

    // Imbalance in WAIT clears the timer.
    set_ld(12'h200, 12'h100);
    step(10);
    check("imb_cnt", 32'(dut_a.u_tmr.cnt_q), 32'd0);
    check("imb_en", 32'(en_a), 32'd0);
    check("imb_state", 32'(dut_a.state_q), 32'(WAIT));

    set_ld(12'h180, 12'h180);
    step(32767);
    check("settle_pre_en", 32'(en_a), 32'd0);
    check("settle_pre_cnt", 32'(dut_a.u_tmr.cnt_q), 32'h7FFF);
    step(1);
    check("settle_en", 32'(en_a), 32'd1);
    check("settle_state", 32'(dut_a.state_q), 32'(STEER));
    step(5);
    check("steer_hold_en", 32'(en_a), 32'd1);
    check("b_steer_en", 32'(en_b), 32'd1);

    // Reset instance b mid-STEER.
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    check("b_rst_en", 32'(en_b), 32'd0);
    check("b_rst_ro", 32'(ro_b), 32'd0);
    check("b_rst_state", 32'(dut_b.state_q), 32'(IDLE));
    check("b_rst_cnt", 32'(dut_b.u_tmr.cnt_q), 32'd0);
    check("a_unaffected", 32'(en_a), 32'd1);

    // 16*diff just under 15*sum keeps STEER.
    set_ld(12'h2E0, 12'h020);
    step(3);
    check("imb_2e0_en", 32'(en_a), 32'd1);
    check("imb_2e0_state", 32'(dut_a.state_q), 32'(STEER));

    // Sum exactly at the loss threshold keeps STEER.
    set_ld(12'h0E0, 12'h0E0);
    step(3);
    check("hyst_steer_en", 32'(en_a), 32'd1);
    check("hyst_steer_ro", 32'(ro_a), 32'd0);

    set_ld(12'h2F0, 12'h010);
    step(1);
    check("imb_2f0_en", 32'(en_a), 32'd0);
    check("imb_2f0_ro", 32'(ro_a), 32'd0);
    check("imb_2f0_state", 32'(dut_a.state_q), 32'(WAIT));
    check("imb_2f0_cnt", 32'(dut_a.u_tmr.cnt_q), 32'd0);
    step(2);
    check("imb_2f0_hold_cnt", 32'(dut_a.u_tmr.cnt_q), 32'd0);

    set_ld(12'h180, 12'h180);
    step(32767);
    check("settle2_pre_en", 32'(en_a), 32'd0);
    step(1);
    check("settle2_en", 32'(en_a), 32'd1);

    // Step-off with hysteresis.
    set_ld(12'h0E0, 12'h0E0);
    step(2);
    check("off_hyst_en", 32'(en_a), 32'd1);
    set_ld(12'h0DF, 12'h0DF);
    step(1);
    check("off_en", 32'(en_a), 32'd0);
    check("off_ro", 32'(ro_a), 32'd1);
    check("off_state", 32'(dut_a.state_q), 32'(IDLE));
    step(1);
    check("off_ro_pulse", 32'(ro_a), 32'd0);
    check("off_idle", 32'(dut_a.state_q), 32'(IDLE));

    // Sum equal to MIN_RIDER_WT does not leave IDLE; one more count does.
    set_ld(12'h100, 12'h100);
    step(3);
    check("min_eq_state", 32'(dut_a.state_q), 32'(IDLE));
    check("min_eq_ro", 32'(ro_a), 32'd0);
    set_ld(12'h101, 12'h100);
    step(1);
    check("min_gt_state", 32'(dut_a.state_q), 32'(WAIT));
    check("min_gt_cnt", 32'(dut_a.u_tmr.cnt_q), 32'd0);

    // Weight loss beats imbalance in WAIT.
    set_ld(12'h1BF, 12'h000);
    step(1);
    check("loss_prio_state", 32'(dut_a.state_q), 32'(IDLE));
    check("loss_prio_ro", 32'(ro_a), 32'd1);
    step(1);
    check("loss_prio_ro_end", 32'(ro_a), 32'd0);

    // Sum at the loss threshold keeps WAIT counting.
    set_ld(12'h180, 12'h180);
    step(1);
    check("rewait_state", 32'(dut_a.state_q), 32'(WAIT));
    set_ld(12'h0E0, 12'h0E0);
    step(3);
    check("hyst_wait_state", 32'(dut_a.state_q), 32'(WAIT));
    check("hyst_wait_cnt", 32'(dut_a.u_tmr.cnt_q), 32'd3);
    check("hyst_wait_ro", 32'(ro_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
